// File: rtl/i2c_byte_ctrl_pkg.sv
// I2C byte controller shared package.
// Bit-controller command encodings and byte FSM states.
package i2c_byte_ctrl_pkg;

  localparam logic [3:0] I2C_CMD_NOP   = 4'b0000;
  localparam logic [3:0] I2C_CMD_START = 4'b0001;
  localparam logic [3:0] I2C_CMD_STOP  = 4'b0010;
  localparam logic [3:0] I2C_CMD_WRITE = 4'b0100;
  localparam logic [3:0] I2C_CMD_READ  = 4'b1000;
  localparam logic [3:0] I2C_CMD_WAIT  = 4'b0011;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_READ  = 3'd2,
    ST_WRITE = 3'd3,
    ST_ACK   = 3'd4,
    ST_STOP  = 3'd5
  } state_t;

endpackage

// File: rtl/i2c_byte_shift.sv
// I2C byte shift register and bit counter.
// Ports: clk, rstn, load/din, shift/sin, clr -> sr, last.
module i2c_byte_shift (
  input  logic       clk,
  input  logic       rstn,
  input  logic       load,
  input  logic       shift,
  input  logic       clr,
  input  logic       sin,
  input  logic [7:0] din,
  output logic [7:0] sr,
  output logic       last
);

  logic [2:0] cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sr  <= 8'h00;
      cnt <= 3'd0;
    end else if (load) begin
      sr  <= din;
      cnt <= 3'd0;
    end else if (shift) begin
      sr  <= {sr[6:0], sin};
      cnt <= cnt + 3'd1;
    end else if (clr) begin
      cnt <= 3'd0;
    end
  end

  // counter wraps 7->0 on the 8th shift
  assign last = (cnt == 3'd7);

endmodule

// File: rtl/i2c_byte_ctrl.sv
// I2C byte-level master sequencer feeding the bit controller.
// Host: start/stop/read/write/ack_in/din -> cmd_ack/ack_out/dout/busy/i2c_al.
// Bit ctrl: core_cmd/core_txd -> core_ack/core_rxd/core_al.
// Option: I2C_BYTE_CTRL_WAIT_EN parks the bus with WAIT between requests.
module i2c_byte_ctrl
  import i2c_byte_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rstn,
  input  logic       ena,
  input  logic       start,
  input  logic       stop,
  input  logic       read,
  input  logic       write,
  input  logic       ack_in,
  input  logic [7:0] din,
  output logic       cmd_ack,
  output logic       ack_out,
  output logic [7:0] dout,
  output logic       busy,
  output logic       i2c_al,
  output logic [3:0] core_cmd,
  output logic       core_txd,
  input  logic       core_ack,
  input  logic       core_rxd,
  input  logic       core_al
);

  state_t     state, state_n;
  logic [3:0] cmd_n;
  logic       txd_n;
  logic       cmd_ack_n;
  logic       al_n;
  logic       busy_n;
  logic       ack_out_n;
  logic [7:0] dout_n;
  logic       load, shift, clr;
  logic       done;
  logic       go;
  logic       wait_exit;
  logic [7:0] sr;
  logic       last;

`ifdef I2C_BYTE_CTRL_WAIT_EN
  localparam logic [3:0] IDLE_CMD = I2C_CMD_WAIT;
  // leave WAIT through one NOP cycle before the next command
  assign wait_exit = (core_cmd == I2C_CMD_WAIT);
`else
  localparam logic [3:0] IDLE_CMD = I2C_CMD_NOP;
  assign wait_exit = 1'b0;
`endif

  // ignore the request still held during the cmd_ack/i2c_al cycle
  assign go = (start | stop | read | write)
            & ~cmd_ack & ~i2c_al;

  i2c_byte_shift u_shift (
    .clk   (clk),
    .rstn  (rstn),
    .load  (load),
    .shift (shift),
    .clr   (clr),
    .sin   (core_rxd),
    .din   (din),
    .sr    (sr),
    .last  (last)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= ST_IDLE;
      core_cmd <= I2C_CMD_NOP;
      core_txd <= 1'b0;
      cmd_ack  <= 1'b0;
      ack_out  <= 1'b0;
      dout     <= 8'h00;
      busy     <= 1'b0;
      i2c_al   <= 1'b0;
    end else begin
      state    <= state_n;
      core_cmd <= cmd_n;
      core_txd <= txd_n;
      cmd_ack  <= cmd_ack_n;
      ack_out  <= ack_out_n;
      dout     <= dout_n;
      busy     <= busy_n;
      i2c_al   <= al_n;
    end
  end

  always_comb begin
    state_n   = state;
    cmd_n     = core_cmd;
    txd_n     = core_txd;
    cmd_ack_n = 1'b0;
    al_n      = 1'b0;
    busy_n    = busy;
    ack_out_n = ack_out;
    dout_n    = dout;
    load      = 1'b0;
    shift     = 1'b0;
    clr       = 1'b0;
    done      = 1'b0;

    if (!ena) begin
      cmd_ack_n = cmd_ack;
      al_n      = i2c_al;
    end else if (core_al && state != ST_IDLE) begin
      state_n = ST_IDLE;
      cmd_n   = I2C_CMD_NOP;
      txd_n   = 1'b0;
      al_n    = 1'b1;
      busy_n  = 1'b0;
      clr     = 1'b1;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (go && wait_exit) begin
            cmd_n = I2C_CMD_NOP;
          end else if (go) begin
            busy_n = 1'b1;
            load   = 1'b1;
            txd_n  = 1'b0;
            priority case (1'b1)
              start: begin
                state_n = ST_START;
                cmd_n   = I2C_CMD_START;
              end
              write: begin
                state_n = ST_WRITE;
                cmd_n   = I2C_CMD_WRITE;
                txd_n   = din[7];
              end
              read: begin
                state_n = ST_READ;
                cmd_n   = I2C_CMD_READ;
              end
              default: begin
                state_n = ST_STOP;
                cmd_n   = I2C_CMD_STOP;
              end
            endcase
          end
        end
        ST_START: begin
          if (core_ack) begin
            priority case (1'b1)
              write: begin
                state_n = ST_WRITE;
                cmd_n   = I2C_CMD_WRITE;
                txd_n   = sr[7];
              end
              read: begin
                state_n = ST_READ;
                cmd_n   = I2C_CMD_READ;
              end
              stop: begin
                state_n = ST_STOP;
                cmd_n   = I2C_CMD_STOP;
              end
              default: done = 1'b1;
            endcase
          end
        end
        ST_WRITE: begin
          if (core_ack) begin
            shift = 1'b1;
            if (last) begin
              state_n = ST_ACK;
              cmd_n   = I2C_CMD_READ;
              txd_n   = 1'b0;
            end else begin
              // sr[6] becomes sr[7] on this edge
              txd_n = sr[6];
            end
          end
        end
        ST_READ: begin
          if (core_ack) begin
            shift = 1'b1;
            if (last) begin
              state_n = ST_ACK;
              cmd_n   = I2C_CMD_WRITE;
              txd_n   = ack_in;
            end
          end
        end
        ST_ACK: begin
          if (core_ack) begin
            if (write) ack_out_n = core_rxd;
            if (stop) begin
              state_n = ST_STOP;
              cmd_n   = I2C_CMD_STOP;
              txd_n   = 1'b0;
            end else begin
              done = 1'b1;
            end
          end
        end
        ST_STOP: begin
          if (core_ack) done = 1'b1;
        end
        default: begin
          state_n = ST_IDLE;
          cmd_n   = I2C_CMD_NOP;
        end
      endcase

      if (done) begin
        state_n   = ST_IDLE;
        cmd_ack_n = 1'b1;
        busy_n    = 1'b0;
        txd_n     = 1'b0;
        cmd_n     = stop ? I2C_CMD_NOP : IDLE_CMD;
        if (read && !write) dout_n = sr;
      end
    end
  end

endmodule
